// File: rtl/bit_serial_alu_if.sv
// Command, status and GPR-side serial signals of the bit-serial ALU.
// The master modport is the controller/GPR side; the slave modport is the ALU.
interface bit_serial_alu_if;
  logic       i_start;
  logic [2:0] i_op;
  logic       i_reg_sel;
  logic       i_dest_acc;
  logic       i_ld;
  logic [7:0] i_imm;
  logic       i_gpr_bit;
  logic       o_con_shift;
  logic       o_con_write;
  logic       o_rd_addr;
  logic       o_data;
  logic [7:0] o_acc;
  logic       o_busy;
  logic       o_done;
  logic       o_carry;
  logic       o_zero;

  modport master (
    output i_start, i_op, i_reg_sel, i_dest_acc, i_ld, i_imm, i_gpr_bit,
    input  o_con_shift, o_con_write, o_rd_addr, o_data, o_acc, o_busy, o_done, o_carry, o_zero
  );

  modport slave (
    input  i_start, i_op, i_reg_sel, i_dest_acc, i_ld, i_imm, i_gpr_bit,
    output o_con_shift, o_con_write, o_rd_addr, o_data, o_acc, o_busy, o_done, o_carry, o_zero
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU/sequencer: combines the GPR LSB stream with an 8-bit accumulator,
// one bit per cycle LSB first, writing results back to the GPR MSB or the accumulator.
module bit_serial_alu #(
  parameter int unsigned W = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  bit_serial_alu_if.slave bus
);
  localparam int unsigned CntW = $clog2(W);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSta = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sel_q, sel_d;
  logic              dest_acc_q, dest_acc_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              c_q, c_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              any_q, any_d;

  logic a, b, nb, r, c_nxt, is_arith, to_acc, to_gpr;
  logic con_shift, con_write, data, busy, done;

  // Bit-level datapath; SUB/CMP add the inverted GPR bit with carry-in preset to 1.
  always_comb begin
    a        = acc_q[0];
    b        = bus.i_gpr_bit;
    is_arith = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpCmp);
    nb       = ((op_q == OpSub) || (op_q == OpCmp)) ? ~b : b;
    r        = 1'b0;
    unique case (op_q)
      OpAdd, OpSub, OpCmp: r = a ^ nb ^ c_q;
      OpAnd:               r = a & b;
      OpOr:                r = a | b;
      OpXor:               r = a ^ b;
      OpLda:               r = b;
      OpSta:               r = a;
      default:             r = 1'b0;
    endcase
    c_nxt  = is_arith ? ((a & nb) | (a & c_q) | (nb & c_q)) : c_q;
    to_acc = (op_q == OpLda) || (dest_acc_q && (op_q != OpSta) && (op_q != OpCmp));
    to_gpr = !to_acc && (op_q != OpCmp);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sel_d      = sel_q;
    dest_acc_d = dest_acc_q;
    acc_d      = acc_q;
    c_d        = c_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    any_d      = any_q;
    con_shift  = 1'b0;
    con_write  = 1'b0;
    data       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d    = StShift;
          op_d       = bus.i_op;
          sel_d      = bus.i_reg_sel;
          dest_acc_d = bus.i_dest_acc;
          cnt_d      = '0;
          any_d      = 1'b0;
          c_d        = (bus.i_op == OpSub) || (bus.i_op == OpCmp);
        end else if (bus.i_ld) begin
          acc_d = bus.i_imm;
        end
      end
      StShift: begin
        busy      = 1'b1;
        con_shift = 1'b1;
        con_write = 1'b1;
        // The operand not receiving the result is rotated so it survives all W cycles.
        data      = to_gpr ? r : b;
        acc_d     = to_acc ? {r, acc_q[W-1:1]} : {a, acc_q[W-1:1]};
        c_d       = c_nxt;
        any_d     = any_q | r;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StDone;
          zero_d  = ~(any_q | r);
          if (is_arith) carry_d = c_nxt;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OpAdd;
      sel_q      <= 1'b0;
      dest_acc_q <= 1'b0;
      acc_q      <= '0;
      c_q        <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      any_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      dest_acc_q <= dest_acc_d;
      acc_q      <= acc_d;
      c_q        <= c_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      any_q      <= any_d;
    end
  end

  assign bus.o_con_shift = con_shift;
  assign bus.o_con_write = con_write;
  assign bus.o_rd_addr   = sel_q;
  assign bus.o_data      = data;
  assign bus.o_acc       = acc_q;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_carry     = carry_q;
  assign bus.o_zero      = zero_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// Bench for bit_serial_alu: two-entry GPR model on the serial side, word-level reference
// model feeding a scoreboard that is checked on every o_done pulse.
module tb_bit_serial_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_alu_if bus ();

  bit_serial_alu #(.W(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Serial GPR file driven by the DUT's shift/write controls; preload port for setup.
  logic [7:0] gpr [2];
  logic       pre_en  = 1'b0;
  logic       pre_sel = 1'b0;
  logic [7:0] pre_val = 8'h00;
  always @(posedge clk) begin
    if (pre_en) gpr[pre_sel] <= pre_val;
    else if (bus.o_con_shift && bus.o_con_write)
      gpr[bus.o_rd_addr] <= {bus.o_data, gpr[bus.o_rd_addr][7:1]};
  end
  assign bus.i_gpr_bit = gpr[bus.o_rd_addr][0];

  typedef struct packed {
    logic [7:0] e_acc;
    logic [7:0] e_rx;
    logic [7:0] e_ry;
    logic       e_carry;
    logic       e_zero;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_gpr [2];
  logic       m_carry = 1'b0;
  logic       m_zero  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Word-level reference: whole 8-bit operation at once.
  task automatic push_expect(input logic [2:0] op, input logic sel, input logic dest,
                             output logic [7:0] new_gpr);
    logic [7:0] g, a, r;
    logic       arith, c;
    g = m_gpr[sel];
    a = m_acc;
    arith = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: begin r = a + g; c = ({1'b0, a} + {1'b0, g}) > 9'd255; arith = 1'b1; end
      3'd1, 3'd7: begin r = a - g; c = (a >= g); arith = 1'b1; end
      3'd2: r = a & g;
      3'd3: r = a | g;
      3'd4: r = a ^ g;
      3'd5: r = g;
      default: r = a;
    endcase
    m_zero = (r == 8'h00);
    if (arith) m_carry = c;
    if (op == 3'd5 || (dest && op != 3'd6 && op != 3'd7)) m_acc = r;
    else if (op != 3'd7) m_gpr[sel] = r;
    new_gpr = m_gpr[sel];
    exp_q.push_back('{e_acc: m_acc, e_rx: m_gpr[1], e_ry: m_gpr[0],
                      e_carry: m_carry, e_zero: m_zero});
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("acc", {24'd0, bus.o_acc}, {24'd0, e.e_acc});
        check("gpr_rx", {24'd0, gpr[1]}, {24'd0, e.e_rx});
        check("gpr_ry", {24'd0, gpr[0]}, {24'd0, e.e_ry});
        check("carry", {31'd0, bus.o_carry}, {31'd0, e.e_carry});
        check("zero", {31'd0, bus.o_zero}, {31'd0, e.e_zero});
      end
    end
  end

  task automatic ld(input logic [7:0] v);
    bus.i_ld = 1'b1;
    bus.i_imm = v;
    @(posedge clk); #1;
    bus.i_ld = 1'b0;
    m_acc = v;
    check("ld_acc", {24'd0, bus.o_acc}, {24'd0, v});
  endtask

  task automatic preload(input logic sel, input logic [7:0] v);
    pre_en = 1'b1;
    pre_sel = sel;
    pre_val = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
    m_gpr[sel] = v;
  endtask

  // Issues one op, records the serial stream, and returns in cycle T+10 (idle).
  task automatic do_op(input logic [2:0] op, input logic sel, input logic dest, input bit noise);
    logic [7:0] exp_stream, stream;
    int cyc, shifts, rd_bad;
    push_expect(op, sel, dest, exp_stream);
    bus.i_start = 1'b1;
    bus.i_op = op;
    bus.i_reg_sel = sel;
    bus.i_dest_acc = dest;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    stream = 8'h00;
    shifts = 0;
    rd_bad = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (bus.o_done) break;
      if (bus.o_con_shift) begin
        stream = {bus.o_data, stream[7:1]};
        shifts++;
        if (bus.o_rd_addr !== sel || bus.o_busy !== 1'b1 || bus.o_con_write !== 1'b1) rd_bad++;
      end
      if (cyc > 20) break;
      @(posedge clk); #1;
      cyc++;
      bus.i_start = noise && (cyc == 2);
      bus.i_ld = noise && (cyc == 2);
      bus.i_imm = 8'hFF;
    end
    check("done_latency", cyc, 8);
    check("shift_count", shifts, 8);
    check("shift_ctrl", rd_bad, 0);
    check("data_stream", {24'd0, stream}, {24'd0, exp_stream});
    if (noise) begin
      bus.i_start = 1'b1;
      bus.i_ld = 1'b1;
      bus.i_imm = 8'hFF;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_ld = 1'b0;
    check("idle_after", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
    check("acc_after", {24'd0, bus.o_acc}, {24'd0, m_acc});
  endtask

  initial begin
    logic done_seen;
    bus.i_start = 1'b0;
    bus.i_op = 3'd0;
    bus.i_reg_sel = 1'b0;
    bus.i_dest_acc = 1'b0;
    bus.i_ld = 1'b0;
    bus.i_imm = 8'h00;
    m_gpr[0] = 8'h00;
    m_gpr[1] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acc", {24'd0, bus.o_acc}, 32'd0);
    check("rst_ctrl", {26'd0, bus.o_busy, bus.o_done, bus.o_carry, bus.o_zero,
                       bus.o_con_shift, bus.o_rd_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    preload(1'b1, 8'h00);
    preload(1'b0, 8'h5A);

    ld(8'h3C); do_op(3'd6, 1'b1, 1'b0, 1'b0);  // STA -> rx = 3C
    ld(8'hF0); do_op(3'd0, 1'b1, 1'b0, 1'b0);  // ADD -> rx = 2C, carry
    ld(8'h00); do_op(3'd1, 1'b1, 1'b1, 1'b0);  // SUB -> acc = D4, borrow
    ld(8'h2C); do_op(3'd7, 1'b1, 1'b0, 1'b1);  // CMP with ignored start/ld
    do_op(3'd7, 1'b1, 1'b0, 1'b0);             // back-to-back

    // Abort an ADD in its 4th shift cycle.
    bus.i_start = 1'b1;
    bus.i_op = 3'd0;
    bus.i_reg_sel = 1'b0;
    bus.i_dest_acc = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_acc", {24'd0, bus.o_acc}, 32'd0);
    check("abort_ctrl", {27'd0, bus.o_busy, bus.o_carry, bus.o_zero, bus.o_con_shift,
                         bus.o_rd_addr}, 32'd0);
    m_acc = 8'h00;
    m_carry = 1'b0;
    m_zero = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_done) done_seen = 1'b1;
    end
    check("abort_no_done", {31'd0, done_seen}, 32'd0);
    @(posedge clk); #1;
    preload(1'b0, 8'($urandom));
    preload(1'b1, 8'($urandom));

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) ld(8'($urandom));
      if ($urandom_range(3) == 0) preload(1'($urandom), 8'($urandom));
      do_op(3'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(4) == 0));
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Bit-serial ALU and sequencer directly downstream of the two-entry bit-serial GPR file; also feeds it.
- Consumes the GPR LSB stream, combines it with an internal 8-bit accumulator, and drives the GPR shift/write controls.
- Writes each result bit back into the GPR MSB or into the accumulator.
- One 8-bit operation takes 8 shift cycles plus one done cycle.

Parameters:
- W, 8, operand width in bits; the GPR is fixed at 8, so only 8 is supported.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start an operation; sampled only in IDLE
- i_op  in  3  opcode, latched at start
- i_reg_sel  in  1  GPR select (0 = ry, 1 = rx), latched at start
- i_dest_acc  in  1  0 = result to GPR, 1 = result to accumulator, latched at start
- i_ld  in  1  parallel accumulator load; honoured only in IDLE when i_start = 0
- i_imm  in  8  data for i_ld
- i_gpr_bit  in  1  GPR serial output: LSB of the selected register
- o_con_shift  out  1  GPR shift enable
- o_con_write  out  1  GPR write enable
- o_rd_addr  out  1  GPR select
- o_data  out  1  bit shifted into the GPR MSB
- o_acc  out  8  accumulator contents
- o_busy  out  1  high in SHIFT and DONE
- o_done  out  1  one-cycle completion pulse
- o_carry  out  1  carry flag
- o_zero  out  1  zero flag

Behaviour:
- Reset: state IDLE; acc = 0, count = 0, carry register = 0, o_carry = 0, o_zero = 0, o_rd_addr = 0.
- Reset: o_con_shift = o_con_write = o_data = o_busy = o_done = 0.
- Reset mid-operation aborts at the next edge with the same values. No partial flag update.
- FSM IDLE -> SHIFT: i_start = 1 in IDLE. Latch op, sel, dest; count = 0.
- Carry register initialised at start: 1 for SUB/CMP, 0 otherwise.
- SHIFT: lasts exactly 8 cycles, count 0..7. SHIFT -> DONE when count = 7.
- DONE: one cycle with o_done = 1; DONE -> IDLE. i_start in SHIFT/DONE is ignored (no queuing).
- Latency: start sampled at edge T; shift cycles T+1..T+8; o_done in cycle T+9; next start accepted from T+10.
- In SHIFT: o_con_shift = 1, o_con_write = 1 (GPR always rewritten so it is never zero-filled), o_rd_addr = latched sel.
- Per-bit signals: a = acc[0], b = i_gpr_bit, c = carry register.
- Result bit r per opcode:
  - 000 ADD: r = a^b^c; c' = maj(a, b, c)
  - 001 SUB (acc - gpr): r = a^~b^c; c' = maj(a, ~b, c)
  - 010 AND: r = a&b
  - 011 OR: r = a|b
  - 100 XOR: r = a^b
  - 101 LDA: r = b; destination forced to acc
  - 110 STA: r = a; destination forced to GPR
  - 111 CMP: as SUB; no destination, both operands rotate unchanged
- Destination GPR: o_data = r; acc rotates right (acc <= {acc[0], acc[7:1]}), so it is preserved after 8 cycles.
- Destination acc: o_data = b (GPR rotates, preserved); acc <= {r, acc[7:1]}.
- o_data is combinational from a, b, c and the latched op. Bits go LSB first.
- Zero tracking: sticky OR of r across the 8 cycles.
- Flag update at the SHIFT -> DONE edge:
  - o_zero = ~(sticky OR) for all ops.
  - o_carry = final c' for ADD/SUB/CMP; held for the other ops.
  - Flags hold between operations.
- SUB/CMP carry convention: 1 = no borrow (acc >= gpr).
- i_ld in IDLE with i_start = 0: acc <= i_imm next edge; flags unchanged. If i_start and i_ld are both high, start wins and i_ld is ignored.
- Outside SHIFT: o_con_shift = o_con_write = o_data = 0; o_rd_addr holds its last value.

Test Plan:
- Reset: hold i_rst 2 cycles -> o_acc = 0x00, o_busy = 0, o_done = 0, o_carry = 0, o_zero = 0, o_con_shift = 0.
- Store: ld 0x3C; STA sel = 1 -> 8 shift cycles with o_rd_addr = 1; o_data sequence 0,0,1,1,1,1,0,0; GPR rx = 0x3C; o_acc = 0x3C; o_done at T+9; o_zero = 0.
- Add: continuing, ld 0xF0; ADD sel = 1 dest = GPR -> rx = 0x2C, o_carry = 1, o_zero = 0, o_acc = 0xF0.
- Subtract and compare:
  - ld 0x00; SUB sel = 1 (rx = 0x2C) dest = acc -> o_acc = 0xD4, o_carry = 0, rx still 0x2C.
  - Then ld 0x2C; CMP sel = 1 -> o_zero = 1, o_carry = 1, acc and rx unchanged.
- Ignored inputs: pulse i_start and i_ld (i_imm = 0xFF) during SHIFT and DONE -> no restart, acc unaffected; exactly one o_done pulse; 10-cycle spacing from a back-to-back start.
- Reset mid-op: assert i_rst in the 4th SHIFT cycle of an ADD -> next cycle IDLE, o_acc = 0, o_carry = 0, o_zero = 0, o_done never pulses.
